// File: rtl/cache_control_if.sv
// CPU-side request bus of the L1 cache controller.
// Ports: mem_read/mem_write/mem_address from the CPU, mem_resp back to it.
interface cache_control_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic        mem_resp;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        input  mem_resp
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        output mem_resp
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a direct-mapped write-back L1 cache: serves hits,
// writes back dirty victims, allocates lines from pmem, counts hits/misses.
// Ports: clk, rst_n (sync, active-low); bus (CPU request/resp);
//   tag_out/valid_out/dirty_out from the arrays; arr_rindex/arr_windex and
//   tag/valid/dirty/data load strobes to the arrays; pmem_read/pmem_write/
//   pmem_address/pmem_resp line port; hit_count/miss_count saturating.
module cache_control #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    localparam int s_tag   = 32 - s_offset - s_index
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_control_if.slave     bus,
    input  logic [s_tag-1:0]   tag_out,
    input  logic               valid_out,
    input  logic               dirty_out,
    output logic [s_index-1:0] arr_rindex,
    output logic [s_index-1:0] arr_windex,
    output logic               tag_load,
    output logic               valid_load,
    output logic               dirty_load,
    output logic               dirty_in,
    output logic               data_load,
    output logic               data_sel,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    input  logic               pmem_resp,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2
    } state_t;

    state_t               state;
    logic [31:s_offset]   req_line;
    logic [s_index-1:0]   idx;
    logic [s_tag-1:0]     cpu_tag;
    logic [s_tag-1:0]     req_tag;
    logic                 req;
    logic                 hit;
    logic                 hit_now;
    logic                 miss_now;
    logic                 unused_offset;

    // Byte-offset bits only matter to the data-array merge, not to control.
    assign unused_offset = ^bus.mem_address[s_offset-1:0];

    assign cpu_tag = bus.mem_address[31 -: s_tag];
    assign req_tag = req_line[31 -: s_tag];
    assign req     = bus.mem_read | bus.mem_write;
    assign hit     = valid_out && (tag_out == cpu_tag);

    // During a miss the latched line address owns the arrays, so a CPU
    // that changes mem_address mid-miss cannot redirect the refill.
    assign idx = (state == IDLE) ? bus.mem_address[s_offset +: s_index]
                                 : req_line[s_offset +: s_index];

    assign hit_now  = rst_n && (state == IDLE) && req && hit;
    assign miss_now = rst_n && (state == IDLE) && req && !hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_line   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_now && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            unique case (state)
                IDLE: begin
                    if (miss_now) begin
                        if (miss_count != 16'hFFFF)
                            miss_count <= miss_count + 16'd1;
                        req_line <= bus.mem_address[31:s_offset];
                        state    <= (valid_out && dirty_out) ? WB : ALLOC;
                    end
                end
                WB: begin
                    if (pmem_resp)
                        state <= ALLOC;
                end
                ALLOC: begin
                    if (pmem_resp)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is held low while rst_n is asserted, so an aborted
    // miss drops its pmem request in the reset cycle itself.
    always_comb begin
        bus.mem_resp = 1'b0;
        arr_rindex   = '0;
        arr_windex   = '0;
        tag_load     = 1'b0;
        valid_load   = 1'b0;
        dirty_load   = 1'b0;
        dirty_in     = 1'b0;
        data_load    = 1'b0;
        data_sel     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        if (rst_n) begin
            arr_rindex = idx;
            arr_windex = idx;
            unique case (state)
                IDLE: begin
                    if (hit_now) begin
                        bus.mem_resp = 1'b1;
                        // mem_write wins when both request lines are high
                        if (bus.mem_write) begin
                            data_load  = 1'b1;
                            dirty_load = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end
                end
                WB: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tag_out, idx, {s_offset{1'b0}}};
                end
                ALLOC: begin
                    pmem_read    = 1'b1;
                    pmem_address = {req_tag, idx, {s_offset{1'b0}}};
                    if (pmem_resp) begin
                        data_load  = 1'b1;
                        data_sel   = 1'b1;
                        tag_load   = 1'b1;
                        valid_load = 1'b1;
                        dirty_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
